// File: rtl/mag_share_arbiter_pkg.sv
// Shared sizing helpers and types for the mag datapath sharing arbiter.
package mag_share_arbiter_pkg;

  localparam int unsigned NumReqDefault   = 4;
  localparam int unsigned WidthInDefault  = 14;
  localparam int unsigned WidthOutDefault = 15;
  localparam int unsigned TagDepthDefault = 4;

  // Width of an index into n items, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of an occupancy counter that must also represent the value 'depth'.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned IdWidth     = idx_width(NumReqDefault);
  localparam int unsigned TagCntWidth = cnt_width(TagDepthDefault);

  typedef logic [IdWidth-1:0] id_t;

endpackage

// File: rtl/mag_share_arbiter_if.sv
// Requester-side and mag-side handshake bundle of the mag sharing arbiter.
interface mag_share_arbiter_if #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned WidthIn  = 14,
  parameter int unsigned WidthOut = 15
);
  // requester -> mag direction
  logic [NumReq-1:0]         valid_i;
  logic [NumReq*WidthIn-1:0] gx_i;
  logic [NumReq*WidthIn-1:0] gy_i;
  logic [NumReq-1:0]         ready_o;
  logic                      mag_valid_o;
  logic [WidthIn-1:0]        mag_gx_o;
  logic [WidthIn-1:0]        mag_gy_o;
  logic                      mag_ready_i;
  // mag -> requester direction
  logic                      mag_valid_i;
  logic [WidthOut-1:0]       mag_i;
  logic                      mag_ready_o;
  logic [NumReq-1:0]         valid_o;
  logic [WidthOut-1:0]       mag_o;
  logic [NumReq-1:0]         ready_i;

  // arbiter view
  modport slave (
    input  valid_i, gx_i, gy_i, mag_ready_i, mag_valid_i, mag_i, ready_i,
    output ready_o, mag_valid_o, mag_gx_o, mag_gy_o, mag_ready_o, valid_o, mag_o
  );

  // environment view (requesters plus the mag instance)
  modport master (
    output valid_i, gx_i, gy_i, mag_ready_i, mag_valid_i, mag_i, ready_i,
    input  ready_o, mag_valid_o, mag_gx_o, mag_gy_o, mag_ready_o, valid_o, mag_o
  );

endinterface

// File: rtl/mag_tag_fifo.sv
// Synchronous FIFO of requester ids tracking beats in flight inside mag.
module mag_tag_fifo
  import mag_share_arbiter_pkg::*;
#(
  parameter int unsigned Depth = TagDepthDefault,
  parameter int unsigned CntW  = TagCntWidth,
  parameter type         tag_t = id_t
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  tag_t            push_id_i,
  input  logic            pop_i,
  output tag_t            head_id_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = idx_width(Depth);

  tag_t            mem_q [Depth];
  tag_t            mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            full;
  logic            do_push;
  logic            do_pop;

  // Pointer, occupancy and storage updates; pointers wrap naturally (Depth is a power of 2).
  always_comb begin
    full     = (cnt_q == CntW'(Depth));
    empty_o  = (cnt_q == '0);
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CntW'(1);
    end
    head_id_o = mem_q[rd_ptr_q];
    count_o   = cnt_q;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mag_share_arbiter.sv
// Round-robin sharing of one in-order mag datapath between NumReq gradient streams.
module mag_share_arbiter
  import mag_share_arbiter_pkg::*;
#(
  parameter int unsigned NumReq   = NumReqDefault,
  parameter int unsigned WidthIn  = WidthInDefault,
  parameter int unsigned WidthOut = WidthOutDefault,
  parameter int unsigned TagDepth = TagDepthDefault
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  mag_share_arbiter_if.slave  bus,
  output logic                err_o
);

  localparam int unsigned IdW  = idx_width(NumReq);
  localparam int unsigned CntW = cnt_width(TagDepth);

  typedef logic [IdW-1:0] rid_t;

  rid_t            rr_ptr_q, rr_ptr_d;
  logic            err_q, err_d;
  rid_t            winner;
  logic            found;
  logic            can_push;
  logic            handshake;
  logic            pop;
  logic            full;
  logic            tag_empty;
  rid_t            head_id;
  logic [CntW-1:0] tag_cnt;

  mag_tag_fifo #(
    .Depth (TagDepth),
    .CntW  (CntW),
    .tag_t (rid_t)
  ) u_tag_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (handshake),
    .push_id_i (winner),
    .pop_i     (pop),
    .head_id_o (head_id),
    .empty_o   (tag_empty),
    .count_o   (tag_cnt)
  );

  // Rotating-priority scan: first valid requester at or after rr_ptr, with wrap.
  always_comb begin
    int unsigned idx;
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = k + 32'(rr_ptr_q);
      if (idx >= NumReq) begin
        idx = idx - NumReq;
      end
      if (!found && bus.valid_i[idx]) begin
        found  = 1'b1;
        winner = rid_t'(idx);
      end
    end
  end

  // Return path: the FIFO head owns whatever result mag presents.
  always_comb begin
    bus.valid_o     = '0;
    bus.mag_ready_o = ~tag_empty & bus.ready_i[head_id];
    bus.mag_o       = bus.mag_i;
    if (bus.mag_valid_i && !tag_empty) begin
      bus.valid_o[head_id] = 1'b1;
    end
    pop = bus.mag_valid_i & bus.mag_ready_o;
  end

  // Forward path: a same-cycle pop frees a slot for a new grant when the FIFO is full.
  always_comb begin
    full            = (tag_cnt == CntW'(TagDepth));
    can_push        = ~full | pop;
    bus.mag_valid_o = (|bus.valid_i) & can_push;
    bus.mag_gx_o    = found ? bus.gx_i[winner*WidthIn +: WidthIn] : '0;
    bus.mag_gy_o    = found ? bus.gy_i[winner*WidthIn +: WidthIn] : '0;
    bus.ready_o     = '0;
    if (found && bus.mag_ready_i && can_push) begin
      bus.ready_o[winner] = 1'b1;
    end
    handshake = bus.mag_valid_o & bus.mag_ready_i;
  end

  // Next round-robin pointer and sticky underflow error.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (handshake) begin
      rr_ptr_d = (winner == rid_t'(NumReq - 1)) ? '0 : winner + rid_t'(1);
    end
    err_d = err_q | (bus.mag_valid_i & tag_empty);
    err_o = err_q;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mag_share_arbiter.sv
// Scoreboard bench for mag_share_arbiter with a behavioural mag and arbitration model.
module tb_mag_share_arbiter;

  localparam int unsigned NUM = 4;
  localparam int unsigned WI  = 14;
  localparam int unsigned WO  = 15;
  localparam int unsigned TD  = 4;

  typedef struct {
    int unsigned id;
    int unsigned val;
  } beat_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic err_o;

  mag_share_arbiter_if #(.NumReq(NUM), .WidthIn(WI), .WidthOut(WO)) bus ();

  mag_share_arbiter #(
    .NumReq   (NUM),
    .WidthIn  (WI),
    .WidthOut (WO),
    .TagDepth (TD)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus),
    .err_o  (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference state: beats accepted by mag and not yet returned, in order.
  beat_t             infl_q[$];
  int unsigned       rr_m   = 0;
  bit                err_m  = 1'b0;
  bit                known  = 1'b0;
  logic signed [WI-1:0] gx_a [NUM];
  logic signed [WI-1:0] gy_a [NUM];
  int                vecs   = 0;
  int                miscmp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned mag_of(input logic signed [WI-1:0] gx, input logic signed [WI-1:0] gy);
    int a, b;
    a = gx;
    b = gy;
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    return int'(a + b);
  endfunction

  // Monitor: compare DUT outputs with the model mid-cycle, then advance the model to the next edge.
  always @(negedge clk_i) begin
    int unsigned w, idx, head;
    bit          found, empty, pop_m, cp, hs, exp_mrdy, exp_mv;
    logic [NUM-1:0] exp_rdy, exp_vo;
    logic [WI-1:0]  exp_gx, exp_gy;
    found = 1'b0;
    w     = 0;
    for (int unsigned k = 0; k < NUM; k++) begin
      idx = (rr_m + k) % NUM;
      if (!found && bus.valid_i[idx]) begin
        found = 1'b1;
        w     = idx;
      end
    end
    empty    = (infl_q.size() == 0);
    head     = empty ? 0 : infl_q[0].id;
    exp_mrdy = !empty && bus.ready_i[head];
    pop_m    = bus.mag_valid_i && exp_mrdy;
    cp       = (infl_q.size() < TD) || pop_m;
    exp_mv   = (|bus.valid_i) && cp;
    hs       = exp_mv && bus.mag_ready_i;
    exp_rdy  = (found && bus.mag_ready_i && cp) ? NUM'(1 << w) : '0;
    exp_vo   = (bus.mag_valid_i && !empty) ? NUM'(1 << head) : '0;
    exp_gx   = found ? gx_a[w] : '0;
    exp_gy   = found ? gy_a[w] : '0;
    if (known) begin
      chk("mag_valid_o", 32'(bus.mag_valid_o), 32'(exp_mv));
      chk("ready_o",     32'(bus.ready_o),     32'(exp_rdy));
      chk("mag_gx_o",    32'(bus.mag_gx_o),    32'(exp_gx));
      chk("mag_gy_o",    32'(bus.mag_gy_o),    32'(exp_gy));
      chk("valid_o",     32'(bus.valid_o),     32'(exp_vo));
      chk("mag_ready_o", 32'(bus.mag_ready_o), 32'(exp_mrdy));
      chk("err_o",       32'(err_o),           32'(err_m));
      if (pop_m) begin
        chk("mag_o", 32'(bus.mag_o), infl_q[0].val);
      end
    end
    if (!rst_ni) begin
      infl_q.delete();
      rr_m  = 0;
      err_m = 1'b0;
      known = 1'b1;
    end else if (known) begin
      if (bus.mag_valid_i && empty) err_m = 1'b1;
      if (pop_m) void'(infl_q.pop_front());
      if (hs) begin
        infl_q.push_back('{id: w, val: mag_of(gx_a[w], gy_a[w])});
        rr_m = (w + 1) % NUM;
      end
    end
  end

  // One stimulus cycle; rdy_blk_head clears the ready bit of the oldest in-flight requester.
  task automatic step(input logic [NUM-1:0] v, input logic mrdy, input logic [NUM-1:0] rdy,
                      input bit rdy_blk_head, input bit ret, input bit force_mv, input bit rst);
    @(posedge clk_i);
    #1;
    rst_ni      = ~rst;
    bus.valid_i = v;
    for (int r = 0; r < NUM; r++) begin
      gx_a[r] = WI'($urandom);
      gy_a[r] = WI'($urandom);
      bus.gx_i[r*WI +: WI] = gx_a[r];
      bus.gy_i[r*WI +: WI] = gy_a[r];
    end
    bus.mag_ready_i = mrdy;
    bus.ready_i     = rdy;
    if (rdy_blk_head && infl_q.size() > 0) bus.ready_i[infl_q[0].id] = 1'b0;
    bus.mag_valid_i = force_mv | (ret && infl_q.size() > 0);
    bus.mag_i       = (infl_q.size() > 0) ? WO'(infl_q[0].val) : WO'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (infl_q.size() > 0 && n < 50) begin
      step('0, 1'b1, '1, 1'b0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    if (infl_q.size() > 0) begin
      miscmp++;
      $display("FAIL drain: %0d beats still in flight after %0d cycles, required 0", infl_q.size(), n);
    end
  endtask

  initial begin
    bus.valid_i = '0; bus.gx_i = '0; bus.gy_i = '0; bus.mag_ready_i = 1'b0;
    bus.mag_valid_i = 1'b0; bus.mag_i = '0; bus.ready_i = '0;
    for (int r = 0; r < NUM; r++) begin gx_a[r] = '0; gy_a[r] = '0; end
    repeat (3) step('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    // all requesters valid, mag always ready, results return immediately
    repeat (20) step(4'hF, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    // only requester 3 valid
    repeat (6) step(4'b1000, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    // no returns: tag FIFO fills, then one return frees a slot in the same cycle
    repeat (8) step(4'hF, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'hF, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(4'hF, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    // head requester back-pressures, then releases
    repeat (4) step('0, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(NUM'($urandom), ($urandom % 4) != 0,
           (($urandom % 5) == 0) ? NUM'($urandom) : '1,
           ($urandom % 8) == 0, ($urandom % 3) != 0, 1'b0, 1'b0);
    end
    drain();
    // reset with three beats in flight
    repeat (3) step(4'hF, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'hF, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step('0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    // result with empty tag FIFO sets the sticky error
    step('0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) step(NUM'($urandom), 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    step('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
